im_loader: RTL and testbench
============================

# im_loader

Boot-time instruction-memory writer for the single-cycle core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to consecutive instruction-memory word addresses starting at 0. The core is held in reset until the image is fully written. The block is the write-side counterpart to the core's word-addressed instruction fetch and sits between the host/UART byte source and the IM write port.

## Interface
- ADDR_W, 10, IM word-address width; DEPTH = 2^ADDR_W words.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- reload  in  1  synchronous pulse: abort and restart loading
- im_we  out  1  IM write enable, one-cycle pulse per word
- im_addr  out  ADDR_W  IM word address
- im_wdata  out  32  IM write data
- cpu_rst_n  out  1  active-low reset to the core; high only after a successful load
- busy  out  1  load in progress (states LEN0..CSUM)
- done  out  1  image loaded successfully
- error  out  1  load failed (length overflow or checksum mismatch)

## Operation
- Stream format:
  - count: 2 bytes, little-endian word count N.
  - payload: N×4 bytes, each word little-endian (the first byte is bits [7:0]).
  - checksum: 1 byte, present only with CHECKSUM_EN.
- A byte transfers on a rising edge where in_valid & in_ready.
- States: LEN0, LEN1, DATA, CSUM, DONE, ERR. State is registered.
- in_ready = 1 in LEN0, LEN1, DATA and CSUM, and 0 in DONE and ERR. It is decoded from state only and has no combinational path from in_valid.
- LEN0: the transferred byte goes to count[7:0] → LEN1.
- LEN1: the transferred byte goes to count[15:8], then:
  - count > DEPTH → ERR.
  - count == 0 → CSUM if CHECKSUM_EN, else DONE.
  - otherwise → DATA.
- DATA:
  - A 2-bit byte index shifts each byte into the word assembly register.
  - On the 4th byte, the word is registered to im_wdata, im_we is set for the next cycle, and im_addr holds the current word index. The word index increments after the pulse.
  - After word N-1 → CSUM if CHECKSUM_EN, else DONE.
- Addresses run 0..N-1 and never wrap. N == DEPTH is legal; the last address is DEPTH-1.
- Word-count arithmetic is 17-bit, so that count == DEPTH compares correctly.
- DONE and ERR are terminal until reload or rst. Bytes presented there are not consumed.
- cpu_rst_n:
  - Low in every state except DONE.
  - Set high on the first edge where state == DONE. This is one cycle after the final im_we pulse, so the core never fetches before the last write lands.
- reload:
  - Has priority over any transfer on the same edge.
  - → LEN0; clears the count, byte index, word index and checksum accumulator.
  - im_we = 0 and cpu_rst_n = 0 from the next cycle.
  - Words already written are not scrubbed.
- done = (state == DONE). error = (state == ERR). busy = !done & !error.

## Timing
- Reset values: state LEN0, in_ready 1, im_we 0, im_addr 0, im_wdata 0, cpu_rst_n 0, busy 1, done 0, error 0.
- Throughput: 1 byte/cycle sustained. in_ready does not drop between words. A 4-byte word yields 1 im_we pulse.
- Write latency: im_we is high the cycle after the edge that accepts the 4th byte of a word.
- Ready-to-run latency: cpu_rst_n rises 2 edges after the edge accepting the final byte (the data byte, or the checksum byte with CHECKSUM_EN).
- in_valid low stalls the loader indefinitely with no state change.
- rst low mid-load: immediate return to reset values. A partial word is discarded and no im_we is issued for it.

## Configuration
- CHECKSUM_EN defined:
  - Running XOR over all payload bytes (count bytes excluded), cleared in LEN0.
  - CSUM accepts 1 byte: equal to the accumulator → DONE; otherwise → ERR and cpu_rst_n stays 0.
  - N == 0 expects checksum 0x00.
- CHECKSUM_EN undefined:
  - No CSUM state and no accumulator.
  - The last data byte goes directly to DONE.

## Test plan
- Stream 02 00 13 00 10 00 | 93 00 20 00, no gaps → im_we at addr 0 data 0x00100013, then addr 1 data 0x00200093. done=1; cpu_rst_n=1 two edges after the last byte.
- Same stream with in_valid toggling every other cycle → identical writes. im_we never asserts on a cycle without a completed word.
- Count 01 04 (N = 1025 > DEPTH = 1024) → ERR on the second byte, zero im_we pulses, in_ready=0, cpu_rst_n=0.
- CHECKSUM_EN, N=1, word bytes 11 22 33 44, checksum 0x44 → DONE. With checksum 0x45 → ERR, cpu_rst_n stays 0.
- reload pulsed after 6 payload bytes, then a fresh N=1 stream → exactly one further im_we at addr 0. busy stays high throughout.
- rst asserted after 2 bytes of word 0 → all outputs at reset values within the same cycle, and no im_we. A subsequent full stream loads correctly.

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write bundle for im_loader.
// The loader sits on the slave side; the byte source and IM/core sit on the master side.
interface im_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              error;

    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, im_we, im_addr, im_wdata, cpu_rst_n, busy, done, error
    );

    modport master (
        output in_data, in_valid, reload,
        input  in_ready, im_we, im_addr, im_wdata, cpu_rst_n, busy, done, error
    );
endinterface

// File: rtl/im_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into IM words
// and releases the core reset once the image is in. Optional trailer check: CHECKSUM_EN.
module im_loader #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    im_loader_if.slave   bus
);
    localparam logic [16:0] DEPTH_W = 17'(1 << ADDR_W);

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
`ifdef CHECKSUM_EN
        CSUM = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

`ifdef CHECKSUM_EN
    localparam state_e END_S = CSUM;
`else
    localparam state_e END_S = DONE;
`endif

    state_e            state_q;
    state_e            state_d;
    logic [15:0]       count_q;
    logic [1:0]        byte_idx_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [23:0]       word_q;
`ifdef CHECKSUM_EN
    logic [7:0]        csum_q;
`endif
    logic              in_ready_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [31:0]       im_wdata_q;
    logic              cpu_rst_n_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic              xfer_s;
    logic [16:0]       count_full_s;
    logic              last_word_s;

    assign xfer_s       = bus.in_valid & in_ready_q;
    assign count_full_s = {1'b0, bus.in_data, count_q[7:0]};
    assign last_word_s  = ((17'(word_idx_q) + 17'd1) == {1'b0, count_q});

    // Next-state decode; reload overrides any transfer on the same edge
    always_comb begin
        state_d = state_q;
        if (bus.reload) begin
            state_d = LEN0;
        end else if (xfer_s) begin
            case (state_q)
                LEN0: state_d = LEN1;
                LEN1: begin
                    if (count_full_s > DEPTH_W) begin
                        state_d = ERR;
                    end else if (count_full_s == 17'd0) begin
                        state_d = END_S;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if ((byte_idx_q == 2'd3) && last_word_s) begin
                        state_d = END_S;
                    end else begin
                        state_d = DATA;
                    end
                end
`ifdef CHECKSUM_EN
                CSUM: begin
                    if (bus.in_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LEN0;
            count_q     <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= '0;
            word_q      <= 24'd0;
`ifdef CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
            in_ready_q  <= 1'b1;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= 32'd0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != DONE) && (state_d != ERR);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERR);
            busy_q      <= (state_d != DONE) && (state_d != ERR);
            // Core release lags DONE by one edge so the last write has landed
            cpu_rst_n_q <= (state_q == DONE) && !bus.reload;
            im_we_q     <= 1'b0;
            if (bus.reload) begin
                count_q    <= 16'd0;
                byte_idx_q <= 2'd0;
                word_idx_q <= '0;
                im_addr_q  <= '0;
`ifdef CHECKSUM_EN
                csum_q     <= 8'd0;
`endif
            end else if (xfer_s) begin
                case (state_q)
                    LEN0: begin
                        count_q[7:0] <= bus.in_data;
`ifdef CHECKSUM_EN
                        csum_q       <= 8'd0;
`endif
                    end
                    LEN1: count_q[15:8] <= bus.in_data;
                    DATA: begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        word_q     <= {bus.in_data, word_q[23:8]};
`ifdef CHECKSUM_EN
                        csum_q     <= csum_q ^ bus.in_data;
`endif
                        if (byte_idx_q == 2'd3) begin
                            im_we_q    <= 1'b1;
                            im_addr_q  <= word_idx_q;
                            im_wdata_q <= {bus.in_data, word_q};
                            word_idx_q <= word_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.im_we     = im_we_q;
    assign bus.im_addr   = im_addr_q;
    assign bus.im_wdata  = im_wdata_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: queue-based write model checked every cycle,
// plus literal expectations for the example streams and timing edges.
module tb_im_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(ADDR_W)) bus ();
    im_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t               exp_q[$];
    logic [ADDR_W-1:0] obs_a[$];
    logic [31:0]       obs_d[$];
    logic [31:0]       img[0:DEPTH-1];
    int                n_cmp = 0;
    int                n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle compare against the write queue and the flag rules
    always @(negedge clk) begin
        if (rst) begin
            chk("busy_rule", {31'd0, bus.busy}, {31'd0, !(bus.done | bus.error)});
            chk("ready_rule", {31'd0, bus.in_ready}, {31'd0, bus.busy});
            chk("run_needs_done", {31'd0, bus.cpu_rst_n & !bus.done}, 32'd0);
            if (bus.im_we) begin
                obs_a.push_back(bus.im_addr);
                obs_d.push_back(bus.im_wdata);
                chk("we_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.im_addr), 32'(e.a));
                    chk("wr_data", bus.im_wdata, e.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("send_timeout", {31'd0, t < 20}, 32'd1);
        if (t < 20) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_im_we"}, {31'd0, bus.im_we}, 32'd0);
        chk({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
        chk({tag, "_im_wdata"}, bus.im_wdata, 32'd0);
        chk({tag, "_cpu_rst_n"}, {31'd0, bus.cpu_rst_n}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    endtask

    // Full image from img[0..n-1]; gap inserts one idle cycle after every byte
    task automatic send_image(input int n, input bit gap);
        logic [15:0] cnt;
        logic [7:0]  cs;
        cnt = 16'(n);
        cs  = 8'd0;
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.a = ADDR_W'(i);
            e.d = img[i];
            exp_q.push_back(e);
        end
        send_byte(cnt[7:0]);
        if (gap) idle(1);
        send_byte(cnt[15:8]);
        if (gap) idle(1);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
                if (k == 3) begin
                    chk("we_latency", {31'd0, bus.im_we}, 32'd1);
                    chk("we_addr_now", 32'(bus.im_addr), 32'(i));
                end
                if (gap) idle(1);
            end
        end
`ifdef CHECKSUM_EN
        send_byte(cs);
`endif
        if (!gap) begin
            chk("img_done", {31'd0, bus.done}, 32'd1);
            chk("img_rst_early", {31'd0, bus.cpu_rst_n}, 32'd0);
            idle(1);
            chk("img_rst_run", {31'd0, bus.cpu_rst_n}, 32'd1);
        end else begin
            chk("img_done_gap", {31'd0, bus.done}, 32'd1);
            chk("img_rst_run_gap", {31'd0, bus.cpu_rst_n}, 32'd1);
        end
        chk("img_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("img_ready_low", {31'd0, bus.in_ready}, 32'd0);
    endtask

    initial begin
        int s;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        #12;
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        check_reset("idle");

        // Example stream, back to back
        img[0] = 32'h0010_0013;
        img[1] = 32'h0020_0093;
        s = obs_a.size();
        send_image(2, 1'b0);
        chk("t1_nwr", 32'(obs_a.size() - s), 32'd2);
        chk("t1_a0", 32'(obs_a[s]), 32'd0);
        chk("t1_d0", obs_d[s], 32'h0010_0013);
        chk("t1_a1", 32'(obs_a[s+1]), 32'd1);
        chk("t1_d1", obs_d[s+1], 32'h0020_0093);
        idle(3);
        chk("t1_done_hold", {31'd0, bus.done}, 32'd1);

        // Same stream with in_valid toggling
        pulse_reload();
        chk("t2_reload_rst", {31'd0, bus.cpu_rst_n}, 32'd0);
        chk("t2_reload_busy", {31'd0, bus.busy}, 32'd1);
        s = obs_a.size();
        send_image(2, 1'b1);
        chk("t2_nwr", 32'(obs_a.size() - s), 32'd2);
        chk("t2_d0", obs_d[s], 32'h0010_0013);
        chk("t2_d1", obs_d[s+1], 32'h0020_0093);

        // Reload after 6 payload bytes, then a fresh one-word image
        pulse_reload();
        begin
            wr_t e;
            e.a = '0;
            e.d = 32'hDDCC_BBAA;
            exp_q.push_back(e);
        end
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        send_byte(8'hFF);
        pulse_reload();
        chk("t3_busy", {31'd0, bus.busy}, 32'd1);
        chk("t3_we_low", {31'd0, bus.im_we}, 32'd0);
        img[0] = 32'h4433_2211;
        s = obs_a.size();
        send_image(1, 1'b0);
        chk("t3_nwr", 32'(obs_a.size() - s), 32'd1);
        chk("t3_a0", 32'(obs_a[s]), 32'd0);
        chk("t3_d0", obs_d[s], 32'h4433_2211);

        // Largest legal image: N == DEPTH
        pulse_reload();
        for (int i = 0; i < DEPTH; i++) img[i] = (32'(i) * 32'h0101_0001) ^ 32'hA5C3_0000;
        s = obs_a.size();
        send_image(DEPTH, 1'b0);
        chk("t4_nwr", 32'(obs_a.size() - s), 32'(DEPTH));
        chk("t4_last_addr", 32'(obs_a[s+DEPTH-1]), 32'(DEPTH - 1));

`ifdef CHECKSUM_EN
        // Trailer mismatch keeps the core in reset
        pulse_reload();
        begin
            wr_t e;
            e.a = '0;
            e.d = 32'h4433_2211;
            exp_q.push_back(e);
        end
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h45);
        chk("cs_bad_err", {31'd0, bus.error}, 32'd1);
        idle(2);
        chk("cs_bad_rst", {31'd0, bus.cpu_rst_n}, 32'd0);
`endif

        // Count overflow: N = 1025
        pulse_reload();
        s = obs_a.size();
        send_byte(8'h01);
        send_byte(8'h04);
        chk("ov_error", {31'd0, bus.error}, 32'd1);
        chk("ov_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("ov_rst", {31'd0, bus.cpu_rst_n}, 32'd0);
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        idle(3);
        bus.in_valid = 1'b0;
        chk("ov_error_hold", {31'd0, bus.error}, 32'd1);
        chk("ov_nwr", 32'(obs_a.size() - s), 32'd0);
        chk("ov_done", {31'd0, bus.done}, 32'd0);

        // Async reset in the middle of word 0, then a clean load
        pulse_reload();
        s = obs_a.size();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        chk("mid_rst_nwr", 32'(obs_a.size() - s), 32'd0);
        img[0] = 32'h0010_0013;
        img[1] = 32'h0020_0093;
        send_image(2, 1'b0);
        chk("t6_nwr", 32'(obs_a.size() - s), 32'd2);
        chk("t6_d1", obs_d[s+1], 32'h0020_0093);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
